// File: rtl/fetch_unit_pkg.sv
// Widths, reset vector and prefetch entry layout for the instruction fetch unit.
`ifndef RISCV_ADDR_WIDTH
`include "riscv_defines.v"
`endif

package fetch_unit_pkg;

   localparam int unsigned ADDR_W = `RISCV_ADDR_WIDTH;
   localparam int unsigned WORD_W = `RISCV_WORD_WIDTH;

   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = ADDR_W'(`RISCV_RESET_PC);
   localparam logic [ADDR_W-1:0] INSTR_BYTES      = ADDR_W'(4);

   // One prefetched instruction together with the address it was fetched from.
   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular prefetch buffer; DEPTH must be a power of two (2 or 4).
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/riscv_defines.v
// Core-wide RISC-V widths and reset vector shared by the front end.
`ifndef RISCV_DEFINES_V
`define RISCV_DEFINES_V

`define RISCV_ADDR_WIDTH 32
`define RISCV_WORD_WIDTH 32
`define RISCV_RESET_PC   32'h0000_0000

`endif

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word reads to a one-cycle RAM and queues them for the decoder.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_valid_o,
   input  logic              mem_ready_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [WORD_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_we_o,
   input  logic [WORD_W-1:0] mem_rdata_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [WORD_W-1:0] instr_o,
   output logic [ADDR_W-1:0] instr_pc_o,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  req_pc;
   logic               inflight;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_push;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_dout;
   fetch_entry_t       push_entry;
   fetch_entry_t       head_entry;

   assign mem_addr_o  = word_align(fetch_pc);
   assign mem_wdata_o = '0;
   assign mem_we_o    = '0;

   // Issue only when a FIFO slot is reserved for the response; a same-cycle pop is not credited.
   assign mem_valid_o = !rst && !redirect_i &&
                        (({1'b0, fifo_count} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(DEPTH));

   assign fifo_push     = mem_ready_i && inflight && !redirect_i && !rst;
   assign instr_valid_o = !rst && (fifo_count != '0);
   assign fifo_pop      = instr_valid_o && instr_ready_i;

   always_comb begin
      push_entry       = '0;
      push_entry.instr = mem_rdata_i;
      push_entry.pc    = req_pc;
   end

   assign fifo_din   = push_entry;
   assign head_entry = fifo_dout;
   assign instr_o    = head_entry.instr;
   assign instr_pc_o = head_entry.pc;

   // Fetch pointer and the single outstanding request tracker.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
      end else if (redirect_i) begin
         fetch_pc <= word_align(redirect_pc_i);
         inflight <= 1'b0;
      end else begin
         inflight <= mem_valid_o;
         if (mem_valid_o) begin
            fetch_pc <= fetch_pc + INSTR_BYTES;
            req_pc   <= mem_addr_o;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (redirect_i),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=4) against a one-cycle-latency RAM model.
module tb_fetch_unit;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_we_o;
   logic [31:0] mem_rdata_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   logic        ram_ready_q = 1'b0;
   logic [31:0] ram_data_q  = '0;
   logic        inject_ready;

   int unsigned n_tests   = 0;
   int unsigned n_fail    = 0;
   int unsigned stale_cnt = 0;
   logic        mon_en    = 1'b0;
   logic [31:0] min_pc    = '0;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_valid_o   (mem_valid_o),
      .mem_ready_i   (mem_ready_i),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_we_o      (mem_we_o),
      .mem_rdata_i   (mem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return ~a ^ 32'h1357_0000;
   endfunction

   // RAM answers every request on the following cycle.
   always @(posedge clk) begin
      ram_ready_q <= mem_valid_o;
      ram_data_q  <= word_at(mem_addr_o);
   end

   assign mem_ready_i = ram_ready_q | inject_ready;
   assign mem_rdata_i = ram_data_q;

   always @(posedge clk) begin
      if (mon_en && instr_valid_o && instr_ready_i && (instr_pc_o < min_pc))
         stale_cnt <= stale_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_fetch(input logic v, input logic [31:0] addr);
      check("mem_valid", 32'(mem_valid_o), 32'(v));
      if (v) check("mem_addr", mem_addr_o, addr);
   endtask

   task automatic expect_instr(input logic v, input logic [31:0] pc);
      check("instr_valid", 32'(instr_valid_o), 32'(v));
      if (v) begin
         check("instr_pc", instr_pc_o, pc);
         check("instr", instr_o, word_at(pc));
      end
   endtask

   initial begin
      rst           = 1'b1;
      instr_ready_i = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      inject_ready  = 1'b0;

      repeat (2) begin
         tick();
         #1;
         expect_fetch(1'b0, 32'h0);
         expect_instr(1'b0, 32'h0);
      end

      // Reset release: back-to-back fetches, first instruction two cycles later.
      rst = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         #1;
         expect_fetch(1'b1, 32'(4 * k));
         if (k >= 2) expect_instr(1'b1, 32'(4 * (k - 2)));
         else        expect_instr(1'b0, 32'h0);
         tick();
      end

      // Decoder stall: head holds, fetch stops once four words are reserved.
      instr_ready_i = 1'b0;
      for (int k = 7; k <= 12; k++) begin
         #1;
         expect_instr(1'b1, 32'h14);
         if (k < 9) expect_fetch(1'b1, 32'(4 * k));
         else       expect_fetch(1'b0, 32'h0);
         tick();
      end

      // Redirect with a full FIFO; unaligned target.
      instr_ready_i = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      #1;
      expect_fetch(1'b0, 32'h0);
      expect_instr(1'b1, 32'h14);
      tick();
      redirect_i = 1'b0;
      min_pc     = 32'h100;
      mon_en     = 1'b1;
      for (int k = 14; k <= 17; k++) begin
         #1;
         expect_fetch(1'b1, 32'h100 + 32'(4 * (k - 14)));
         if (k >= 16) expect_instr(1'b1, 32'h100 + 32'(4 * (k - 16)));
         else         expect_instr(1'b0, 32'h0);
         tick();
      end

      // Redirect coinciding with the response for 0x10C.
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      #1;
      expect_fetch(1'b0, 32'h0);
      expect_instr(1'b1, 32'h108);
      tick();
      redirect_i = 1'b0;
      min_pc     = 32'h200;
      for (int k = 19; k <= 21; k++) begin
         #1;
         expect_fetch(1'b1, 32'h200 + 32'(4 * (k - 19)));
         if (k == 21) expect_instr(1'b1, 32'h200);
         else         expect_instr(1'b0, 32'h0);
         tick();
      end

      // Back-to-back redirects: the second target wins.
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0300;
      #1;
      expect_fetch(1'b0, 32'h0);
      expect_instr(1'b1, 32'h204);
      tick();
      redirect_pc_i = 32'h0000_0400;
      #1;
      expect_fetch(1'b0, 32'h0);
      expect_instr(1'b0, 32'h0);
      tick();
      redirect_i = 1'b0;
      min_pc     = 32'h400;
      for (int k = 24; k <= 26; k++) begin
         #1;
         expect_fetch(1'b1, 32'h400 + 32'(4 * (k - 24)));
         if (k == 26) expect_instr(1'b1, 32'h400);
         else         expect_instr(1'b0, 32'h0);
         tick();
      end
      check("no_stale_pc", stale_cnt, 32'd0);
      mon_en = 1'b0;

      // Address wrap at the top of memory.
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFF;
      #1;
      expect_fetch(1'b0, 32'h0);
      expect_instr(1'b1, 32'h404);
      tick();
      redirect_i = 1'b0;
      for (int k = 28; k <= 31; k++) begin
         #1;
         expect_fetch(1'b1, 32'hFFFF_FFFC + 32'(4 * (k - 28)));
         if (k >= 30) expect_instr(1'b1, 32'hFFFF_FFFC + 32'(4 * (k - 30)));
         else         expect_instr(1'b0, 32'h0);
         tick();
      end

      // Reset while a request is outstanding; its response must be dropped.
      rst = 1'b1;
      #1;
      expect_fetch(1'b0, 32'h0);
      expect_instr(1'b0, 32'h0);
      tick();
      rst          = 1'b0;
      inject_ready = 1'b1;
      #1;
      expect_fetch(1'b1, 32'h0);
      expect_instr(1'b0, 32'h0);
      tick();
      inject_ready = 1'b0;
      #1;
      expect_fetch(1'b1, 32'h4);
      expect_instr(1'b0, 32'h0);
      tick();
      #1;
      expect_instr(1'b1, 32'h0);
      check("mem_wdata", mem_wdata_o, 32'h0);
      check("mem_we", 32'(mem_we_o), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
